// File: rtl/reg_mailbox_player_if.sv
// Regfile write-port snoop bundle for the mailbox player.
// The processor side drives it and the player only listens.
interface reg_mailbox_player_if;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;

   modport master (
      output ctrl_writeEnable,
      output ctrl_writeReg,
      output data_writeReg
   );

   modport slave (
      input ctrl_writeEnable,
      input ctrl_writeReg,
      input data_writeReg
   );
endinterface

// File: rtl/reg_mailbox_player.sv
// Mailbox reader: queues regfile writes to MBOX_REG and plays
// each command's LED pattern for its hold time in ticks.
module reg_mailbox_player #(
   parameter int MBOX_REG = 29,
   parameter int DEPTH    = 4,
   parameter int TICK_DIV = 50000
) (
   input  logic                     clk,
   input  logic                     reset,
   reg_mailbox_player_if.slave      wr,
   output logic [11:0]              led,
   output logic                     busy,
   output logic                     cmd_done,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {
      IDLE,
      SHOW
   } state_e;

   state_e        state_q, state_d;
   logic [27:0]   mem_q [DEPTH];
   logic [27:0]   mem_d [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   rem_q, rem_d;
   logic [11:0]   led_q, led_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;

   logic          hit;
   logic          flush;
   logic          push_req;
   logic          push_ok;
   logic          pop;
   logic          empty;
   logic          full;
   logic [27:0]   head;
   logic          unused_bits;

   assign unused_bits = ^wr.data_writeReg[30:28];

   // Decode the snooped write and derive FIFO status.
   always_comb begin
      hit      = wr.ctrl_writeEnable
               && (wr.ctrl_writeReg == 5'(MBOX_REG));
      flush    = hit && wr.data_writeReg[31];
      push_req = hit && !wr.data_writeReg[31];
      empty    = (count_q == '0);
      full     = (count_q == FULL);
      head     = mem_q[rptr_q];
   end

   // Player FSM, FIFO bookkeeping and flush override.
   always_comb begin
      state_d = state_q;
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      presc_d = presc_q;
      rem_d   = rem_q;
      led_d   = led_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      pop     = 1'b0;
      push_ok = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop = 1'b1;
            end
         end
         SHOW: begin
            if (presc_q == PMAX) begin
               presc_d = '0;
               if (rem_q <= 16'd1) begin
                  done_d = 1'b1;
                  if (!empty) begin
                     pop = 1'b1;
                  end else begin
                     led_d   = '0;
                     busy_d  = 1'b0;
                     rem_d   = '0;
                     state_d = IDLE;
                  end
               end else begin
                  rem_d = rem_q - 16'd1;
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Loading the head entry: a zero hold still shows one tick.
      if (pop) begin
         led_d   = head[11:0];
         rem_d   = (head[27:12] == '0) ? 16'd1 : head[27:12];
         presc_d = '0;
         busy_d  = 1'b1;
         state_d = SHOW;
         rptr_d  = rptr_q + AW'(1);
      end

      push_ok = push_req && (!full || pop);
      if (push_req && !push_ok) begin
         ovf_d = 1'b1;
      end
      if (push_ok) begin
         mem_d[wptr_q] = wr.data_writeReg[27:0];
         wptr_d        = wptr_q + AW'(1);
      end

      count_d = count_q + CW'(push_ok) - CW'(pop);

      // A flush wins over everything computed above.
      if (flush) begin
         state_d = IDLE;
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         presc_d = '0;
         rem_d   = '0;
         led_d   = '0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         ovf_d   = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         presc_q <= '0;
         rem_q   <= '0;
         led_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         presc_q <= presc_d;
         rem_q   <= rem_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign led        = led_q;
   assign busy       = busy_q;
   assign cmd_done   = done_q;
   assign fifo_count = count_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_reg_mailbox_player.sv
// Directed bench for reg_mailbox_player with TICK_DIV = 2.
// Expected values are hand-derived cycle by cycle.
module tb_reg_mailbox_player;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] led;
   logic        busy;
   logic        cmd_done;
   logic [2:0]  fifo_count;
   logic        overflow;

   int vecs = 0;
   int errs = 0;

   reg_mailbox_player_if wif ();

   reg_mailbox_player #(
      .MBOX_REG (29),
      .DEPTH    (4),
      .TICK_DIV (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr         (wif.slave),
      .led        (led),
      .busy       (busy),
      .cmd_done   (cmd_done),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h @%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_cmd(input logic [4:0] idx,
                         input logic en,
                         input logic [31:0] data);
      wif.ctrl_writeEnable = en;
      wif.ctrl_writeReg    = idx;
      wif.data_writeReg    = data;
      step();
      wif.ctrl_writeEnable = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!cmd_done && n < 400);
      if (!cmd_done) chk("done_timeout", 0, 1);
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_led"}, 32'(led), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_cnt"}, 32'(fifo_count), 0);
   endtask

   initial begin
      int n;
      logic [11:0] exp_led [6];
      logic        exp_dn  [6];

      wif.ctrl_writeEnable = 1'b0;
      wif.ctrl_writeReg    = '0;
      wif.data_writeReg    = '0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;

      // reset state
      idle_chk("rst");
      chk("rst_done", 32'(cmd_done), 0);
      chk("rst_ovf", 32'(overflow), 0);

      // 1: single command, hold 3 -> 6 cycles
      wr_cmd(5'd29, 1'b1, 32'h0000_30A5);
      chk("t1_cnt", 32'(fifo_count), 1);
      chk("t1_led0", 32'(led), 0);
      step();
      for (int i = 0; i < 6; i++) begin
         chk("t1_led", 32'(led), 32'h0A5);
         chk("t1_busy", 32'(busy), 1);
         chk("t1_dn0", 32'(cmd_done), 0);
         step();
      end
      chk("t1_end_led", 32'(led), 0);
      chk("t1_end_busy", 32'(busy), 0);
      chk("t1_done", 32'(cmd_done), 1);
      step();
      chk("t1_done_off", 32'(cmd_done), 0);

      // 2: wrong register and enable low are ignored
      wr_cmd(5'd28, 1'b1, 32'h0000_30A5);
      wr_cmd(5'd29, 1'b0, 32'h0000_30A5);
      step();
      idle_chk("t2");
      chk("t2_ovf", 32'(overflow), 0);

      // hold of 0 is shown for one tick
      wr_cmd(5'd29, 1'b1, 32'h0000_0055);
      step();
      chk("h0_led_a", 32'(led), 32'h055);
      step();
      chk("h0_led_b", 32'(led), 32'h055);
      step();
      chk("h0_led_off", 32'(led), 0);
      chk("h0_done", 32'(cmd_done), 1);
      step();

      // 3: back-to-back patterns, no blank between
      wr_cmd(5'd29, 1'b1, 32'h0000_1001);
      wr_cmd(5'd29, 1'b1, 32'h0000_1002);
      wr_cmd(5'd29, 1'b1, 32'h0000_1004);
      chk("t3_cnt", 32'(fifo_count), 2);
      exp_led = '{12'h001, 12'h002, 12'h002,
                  12'h004, 12'h004, 12'h000};
      exp_dn  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         chk("t3_led", 32'(led), 32'(exp_led[i]));
         chk("t3_done", 32'(cmd_done), 32'(exp_dn[i]));
         step();
      end
      chk("t3_idle", 32'(busy), 0);

      // 4: overflow with hold 100, then ordered playout
      for (int i = 1; i <= 6; i++) begin
         wr_cmd(5'd29, 1'b1, 32'h0006_4000 | 32'(i));
      end
      chk("t4_cnt", 32'(fifo_count), 4);
      chk("t4_ovf", 32'(overflow), 1);
      chk("t4_led1", 32'(led), 1);
      wait_done(n);
      chk("t4_gap1", 32'(n), 196);
      chk("t4_led2", 32'(led), 2);
      for (int p = 3; p <= 5; p++) begin
         wait_done(n);
         chk("t4_gap", 32'(n), 200);
         chk("t4_led", 32'(led), 32'(p));
      end
      wait_done(n);
      chk("t4_gap5", 32'(n), 200);
      idle_chk("t4_end");
      chk("t4_ovf_sticky", 32'(overflow), 1);
      step();

      // 5: flush while showing with two entries queued
      wr_cmd(5'd29, 1'b1, 32'h0006_400A);
      wr_cmd(5'd29, 1'b1, 32'h0006_400B);
      wr_cmd(5'd29, 1'b1, 32'h0006_400C);
      chk("t5_led", 32'(led), 32'h00A);
      chk("t5_cnt", 32'(fifo_count), 2);
      wr_cmd(5'd29, 1'b1, 32'h8000_0000);
      idle_chk("t5_flush");
      chk("t5_ovf", 32'(overflow), 0);
      chk("t5_done", 32'(cmd_done), 0);
      step();
      idle_chk("t5_after");
      chk("t5_done2", 32'(cmd_done), 0);

      // 6: reset mid-SHOW with entries queued
      wr_cmd(5'd29, 1'b1, 32'h0006_4111);
      wr_cmd(5'd29, 1'b1, 32'h0006_4222);
      wr_cmd(5'd29, 1'b1, 32'h0006_4333);
      step();
      chk("t6_pre", 32'(busy), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle_chk("t6_rst");
      chk("t6_done", 32'(cmd_done), 0);
      chk("t6_ovf", 32'(overflow), 0);
      step();
      idle_chk("t6_hold");
      wr_cmd(5'd29, 1'b1, 32'h0000_1777);
      chk("t6_cnt", 32'(fifo_count), 1);
      chk("t6_led0", 32'(led), 0);
      step();
      chk("t6_led", 32'(led), 32'h777);
      chk("t6_busy", 32'(busy), 1);
      step();
      step();
      chk("t6_done_end", 32'(cmd_done), 1);
      chk("t6_led_end", 32'(led), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vecs, errs);
      $finish;
   end

endmodule

// File: doc/reg_mailbox_player.md
# reg_mailbox_player

Processor-to-hardware mailbox reader for the whack-a-mole game top. It snoops the regfile write port and captures every processor write to a dedicated mailbox register. Each captured command word is queued in a small FIFO and played out to the 12 game LEDs for a programmed hold time. This is the counterpart of the score path: score flows from hardware into r30, and LED/timing commands flow from software out to hardware through this block.

## Interface
Parameters:
- MBOX_REG, 29, regfile index that is snooped; legal range 1..31.
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- TICK_DIV, 50000, clock cycles per hold tick (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- ctrl_writeEnable  in  1  regfile write enable (the final, muxed value).
- ctrl_writeReg  in  5  regfile write index.
- data_writeReg  in  32  regfile write data.
- led  out  12  displayed pattern.
- busy  out  1  high while a pattern is being shown.
- cmd_done  out  1  one-cycle pulse when a pattern's hold time expires.
- fifo_count  out  $clog2(DEPTH)+1  number of queued, not-yet-shown entries.
- overflow  out  1  sticky flag; a command was dropped because the FIFO was full.

## Operation
**Command word**
- [11:0]: LED pattern.
- [27:12]: hold, in ticks. A hold of 0 is treated as 1.
- [30:28]: ignored.
- [31]: flush. When set, all other fields are ignored.

**Capture**
- A command is captured when ctrl_writeEnable is 1 and ctrl_writeReg equals MBOX_REG.
- All other writes, and any cycle with the enable low, are ignored.
- Words with bit 31 = 0 are pushed to the FIFO.
- Words with bit 31 = 1 perform a flush and are not queued.

**Flush**
- FIFO emptied, led goes to 0, state goes to IDLE, overflow cleared.
- No cmd_done pulse is generated.
- A flush overrides any push, pop or hold expiry in the same cycle.

**State machine: IDLE**
- busy is 0 and led is 0.
- When the FIFO is non-empty, pop the head, load the pattern and hold, and go to SHOW.

**State machine: SHOW**
- busy is 1 and led equals the loaded pattern.
- A tick prescaler counts 0..TICK_DIV-1.
- The remaining-tick counter decrements on each prescaler wrap.
- Expiry occurs when the last tick completes. On expiry:
  - cmd_done pulses.
  - If the FIFO is non-empty, pop and load the next entry the same cycle and stay in SHOW. There is no blank cycle between patterns.
  - Otherwise led goes to 0 and state goes to IDLE.

**FIFO**
- Circular buffer with read and write pointers that wrap modulo DEPTH.
- A push when full with no pop in the same cycle: the word is dropped, existing contents are preserved, and overflow is set.
- A push and a pop in the same cycle while full: both succeed and the count is unchanged.
- A push into an empty FIFO while IDLE: the entry is popped on the following cycle.

## Timing
- Reset values: led = 0, busy = 0, cmd_done = 0, fifo_count = 0, overflow = 0, state = IDLE, all counters 0.
- Latency: a write sampled at edge N is counted in fifo_count after edge N.
  - IDLE pops at edge N+1, so led and busy change after edge N+1.
  - Write-to-LED latency is 2 cycles.
- Hold: led shows the pattern for exactly max(hold,1) × TICK_DIV cycles.
- cmd_done is high in the cycle after the last displayed cycle, which is the cycle led takes its next value.
- Reset asserted mid-SHOW: all outputs return to reset values after that edge, the FIFO is emptied, and no cmd_done is generated.
- Every output is registered; nothing is combinational from the inputs.

## Test plan
All scenarios use TICK_DIV = 2.

1. Write 0x0000_30A5 to r29 at cycle N.
   - led = 0x0A5 and busy = 1 from N+2 for 6 cycles.
   - Then led = 0, busy = 0, and cmd_done pulses once.
2. Write 0x0000_30A5 to r28, and separately drive 0x0000_30A5 with index 29 but ctrl_writeEnable = 0.
   - led, fifo_count and overflow all stay 0.
3. Three consecutive r29 writes with patterns 0x001, 0x002, 0x004, each with hold 1.
   - led shows 0x001, 0x002, 0x004, 2 cycles each, with no zero between them.
   - Three cmd_done pulses; then led = 0.
4. Six consecutive r29 writes, each with hold 100.
   - The first is shown; entries 2-5 are queued and fifo_count = 4.
   - The sixth is dropped and overflow = 1.
   - Later playout order is 2, 3, 4, 5.
5. While in SHOW with 2 entries queued, write 0x8000_0000 to r29.
   - Next cycle: led = 0, busy = 0, fifo_count = 0, overflow = 0, and no cmd_done.
6. Assert reset for 1 cycle in the middle of SHOW with entries queued.
   - All outputs are 0 after the edge.
   - A subsequent write plays normally with 2-cycle latency.
